// File: rtl/battle_pkg.sv
// rtl/battle_pkg.sv - shared turn-sequencer types, sizes and the saturating HP subtract
package battle_pkg;

  localparam int NUM_MON_C = 3;
  localparam int HP_W_C    = 8;

  localparam logic PLAYER = 1'b1;
  localparam logic ENEMY  = 1'b0;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ORDER,
    S_CALC,
    S_APPLY,
    S_SHOW,
    S_CHECK,
    S_END,
    S_WIN,
    S_LOSE
  } ts_state_e;

  function automatic logic [HP_W_C-1:0] sat_sub(input logic [HP_W_C-1:0] hp,
                                                input logic [HP_W_C-1:0] dmg);
    return (hp > dmg) ? hp - dmg : '0;
  endfunction

endpackage

// File: rtl/next_alive.sv
// rtl/next_alive.sv - next conscious mon after a faint, scanning forward with wraparound
module next_alive #(
  parameter int NUM_MON = 3,
  parameter int HP_W    = 8
) (
  input  logic [NUM_MON*HP_W-1:0] i_hp,
  input  logic [1:0]              i_idx,
  output logic [1:0]              o_next_idx,
  output logic                    o_all_zero
);

  int w_slot;

  always_comb begin
    o_next_idx = i_idx;
    o_all_zero = 1'b1;
    w_slot     = 0;
    for (int m = 0; m < NUM_MON; m++) begin
      if (i_hp[m*HP_W +: HP_W] != '0) o_all_zero = 1'b0;
    end
    // Scan descending so the smallest forward distance to a live mon wins.
    for (int k = NUM_MON - 1; k >= 1; k--) begin
      w_slot = (int'(i_idx) + k) % NUM_MON;
      if (i_hp[w_slot*HP_W +: HP_W] != '0) o_next_idx = w_slot[1:0];
    end
  end

endmodule

// File: rtl/turn_sequencer.sv
// rtl/turn_sequencer.sv - one battle turn: speed order, damage handshake, HP apply, faint/switch, win/lose
// SPEED_TIE_LFSR_EN: speed ties decided by an 8-bit LFSR instead of always favouring the player.
module turn_sequencer
  import battle_pkg::*;
#(
  parameter int NUM_MON = NUM_MON_C,
  parameter int HP_W    = HP_W_C,
  parameter int SPD_W   = 8
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    load_hp,
  input  logic [NUM_MON*HP_W-1:0] player_hp_init,
  input  logic [NUM_MON*HP_W-1:0] enemy_hp_init,
  input  logic                    start_turn,
  input  logic [1:0]              player_move,
  input  logic [1:0]              enemy_move,
  input  logic [SPD_W-1:0]        player_speed,
  input  logic [SPD_W-1:0]        enemy_speed,
  input  logic                    key_confirm,
  output logic                    calc_req,
  output logic                    calc_is_player,
  output logic [1:0]              calc_move,
  input  logic                    calc_ack,
  input  logic [HP_W-1:0]         calc_damage,
  output logic [NUM_MON*HP_W-1:0] player_hp,
  output logic [NUM_MON*HP_W-1:0] enemy_hp,
  output logic [1:0]              cur_mon,
  output logic [1:0]              opp_mon,
  output logic                    msg_valid,
  output logic                    msg_is_player,
  output logic [1:0]              msg_move,
  output logic                    busy,
  output logic                    turn_done,
  output logic                    battle_over,
  output logic                    result
);

  ts_state_e               r_state, w_next;
  logic [NUM_MON*HP_W-1:0] r_player_hp, r_enemy_hp;
  logic [1:0]              r_cur, r_opp, r_pmove, r_emove;
  logic                    r_loaded, r_atk, r_att_player, r_over, r_result;
  logic [HP_W-1:0]         r_dmg, w_def_hp;
  logic [1:0]              w_p_next, w_e_next;
  logic                    w_p_all0, w_e_all0, w_def_team_dead, w_tie_bit, w_player_first;

`ifdef SPEED_TIE_LFSR_EN
  logic [7:0] r_lfsr;
  always_ff @(posedge Clk) begin
    if (Reset) r_lfsr <= 8'hA5;
    else       r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
  end
  assign w_tie_bit = r_lfsr[0];
`else
  assign w_tie_bit = 1'b1;
`endif

  assign w_player_first = (player_speed > enemy_speed) ||
                          ((player_speed == enemy_speed) && w_tie_bit);

  // The defender is always the side opposite the current attacker.
  assign w_def_hp        = (r_att_player == PLAYER) ? r_enemy_hp[r_opp*HP_W +: HP_W]
                                                    : r_player_hp[r_cur*HP_W +: HP_W];
  assign w_def_team_dead = (r_att_player == PLAYER) ? w_e_all0 : w_p_all0;

  next_alive #(.NUM_MON(NUM_MON), .HP_W(HP_W)) u_next_player (
    .i_hp(r_player_hp), .i_idx(r_cur), .o_next_idx(w_p_next), .o_all_zero(w_p_all0)
  );
  next_alive #(.NUM_MON(NUM_MON), .HP_W(HP_W)) u_next_enemy (
    .i_hp(r_enemy_hp), .i_idx(r_opp), .o_next_idx(w_e_next), .o_all_zero(w_e_all0)
  );

  assign player_hp   = r_player_hp;
  assign enemy_hp    = r_enemy_hp;
  assign cur_mon     = r_cur;
  assign opp_mon     = r_opp;
  assign battle_over = r_over;
  assign result      = r_result;

  always_comb begin
    w_next         = r_state;
    calc_req       = 1'b0;
    calc_is_player = 1'b0;
    calc_move      = 2'd0;
    msg_valid      = 1'b0;
    msg_is_player  = 1'b0;
    msg_move       = 2'd0;
    busy           = 1'b1;
    turn_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (!load_hp && start_turn && r_loaded) w_next = S_ORDER;
      end
      S_ORDER: w_next = S_CALC;
      S_CALC: begin
        calc_req       = 1'b1;
        calc_is_player = r_att_player;
        calc_move      = r_att_player ? r_pmove : r_emove;
        if (calc_ack) w_next = S_APPLY;
      end
      S_APPLY: w_next = S_SHOW;
      S_SHOW: begin
        msg_valid     = 1'b1;
        msg_is_player = r_att_player;
        msg_move      = r_att_player ? r_pmove : r_emove;
        if (key_confirm) w_next = S_CHECK;
      end
      S_CHECK: begin
        if (w_def_hp == '0) begin
          if (w_def_team_dead) w_next = (r_att_player == PLAYER) ? S_WIN : S_LOSE;
          else                 w_next = S_END;
        end else if (!r_atk) begin
          w_next = S_CALC;
        end else begin
          w_next = S_END;
        end
      end
      S_END: begin
        turn_done = 1'b1;
        w_next    = S_IDLE;
      end
      S_WIN, S_LOSE: begin
        busy = 1'b0;
        if (load_hp) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state      <= S_IDLE;
      r_player_hp  <= '0;
      r_enemy_hp   <= '0;
      r_cur        <= 2'd0;
      r_opp        <= 2'd0;
      r_pmove      <= 2'd0;
      r_emove      <= 2'd0;
      r_loaded     <= 1'b0;
      r_atk        <= 1'b0;
      r_att_player <= ENEMY;
      r_over       <= 1'b0;
      r_result     <= 1'b0;
      r_dmg        <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE, S_WIN, S_LOSE: begin
          if (load_hp) begin
            r_player_hp <= player_hp_init;
            r_enemy_hp  <= enemy_hp_init;
            r_cur       <= 2'd0;
            r_opp       <= 2'd0;
            r_over      <= 1'b0;
            r_result    <= 1'b0;
            r_loaded    <= 1'b1;
          end else if (w_next == S_ORDER) begin
            r_pmove <= player_move;
            r_emove <= enemy_move;
          end
        end
        S_ORDER: begin
          r_att_player <= w_player_first ? PLAYER : ENEMY;
          r_atk        <= 1'b0;
        end
        S_CALC: if (calc_ack) r_dmg <= calc_damage;
        S_APPLY: begin
          if (r_att_player == PLAYER) r_enemy_hp[r_opp*HP_W +: HP_W]  <= sat_sub(w_def_hp, r_dmg);
          else                        r_player_hp[r_cur*HP_W +: HP_W] <= sat_sub(w_def_hp, r_dmg);
        end
        S_CHECK: begin
          if (w_def_hp == '0) begin
            if (w_def_team_dead) begin
              r_over   <= 1'b1;
              r_result <= (r_att_player == PLAYER);
            end else if (r_att_player == PLAYER) begin
              r_opp <= w_e_next;
            end else begin
              r_cur <= w_p_next;
            end
          end else if (!r_atk) begin
            r_atk        <= 1'b1;
            r_att_player <= ~r_att_player;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
